t_to_s: RTL and testbench
=========================

Name: t_to_s

Overview:
- Converts W-bit two's-complement LDPC messages into (W+1)-bit sign-magnitude form: sign bit, then magnitude.
- Sits between the two's-complement check/variable-node arithmetic and the sign-magnitude min-finding logic.
- Processes LANES independent messages per cycle through a single registered pipeline stage.

Parameters:
- W, 7, input width in bits (two's complement); output lane width is W+1.
- LANES, 1, number of messages converted in parallel per cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  inp carries valid data this cycle.
- inp  input  LANES*W  packed two's-complement inputs; lane k is bits [k*W +: W].
- out_valid  output  1  out carries converted data.
- out  output  LANES*(W+1)  packed sign-magnitude outputs; lane k is bits [k*(W+1) +: W+1].

Behaviour:
- One clock, asynchronous active-low reset. While rst_n is 0: out = 0 and out_valid = 0, immediately and independent of clk.
- Per-lane conversion, combinational:
  - Sign s = inp[W-1].
  - Magnitude m = (s ? -inp : inp), computed at W+1 bits after sign-extending inp to W+1 bits. Always take the low W bits of m.
  - Lane output = {s, m[W-1:0]}.
- Full-range requirement: the most negative input -2^(W-1) maps to magnitude 2^(W-1). For W=7, 1000000 -> 1_1000000. No saturation and no overflow. This is why the output is one bit wider than the input.
- Zero maps to positive zero (all bits 0). Negative zero is never produced.
- Latency: exactly 1 cycle.
  - If in_valid is 1 at a rising edge, out takes the converted inp and out_valid is 1 after that edge.
  - If in_valid is 0 at an edge, out_valid goes to 0 and out holds its previous value.
- No backpressure; a new input is accepted every cycle. Back-to-back valid inputs yield back-to-back valid outputs.
- Lanes are fully independent; there is no cross-lane interaction.
- Reset mid-stream: an in-flight result is discarded. The first valid output after reset release comes 1 edge after the first in_valid=1 edge.
- X on inp while in_valid is 0 must not reach out.

Decomposition:
- Shared package ldpc_pkg holds:
  - MSG_W = 7
  - SM_W = MSG_W + 1
  - A sign-magnitude struct typedef {logic sign; logic [MSG_W-1:0] mag;}
- Sub-module t_to_s_lane: purely combinational, W-bit to (W+1)-bit converter. Instantiate it LANES times via generate.
- The top level holds only the output and valid registers plus lane packing.

Test Plan:
1. W=7, LANES=1, in_valid=1, inp=1101100 (-20) -> next cycle out=10010100, out_valid=1.
2. Consecutive cycles: inp=1111000 (-8) then 0101010 (+42) then 0010101 (+21) -> out=10001000, 00101010, 00010101 on consecutive cycles, out_valid held at 1.
3. Boundaries:
   - inp=1000000 (-64) -> 11000000.
   - inp=0111111 (+63) -> 00111111.
   - inp=0000000 -> 00000000.
   - inp=1111111 (-1) -> 10000001.
4. Exhaustive sweep of all 128 inputs, compared against the reference formula {s, |value|}, with 1-cycle latency checked on each.
5. Reset behaviour:
   - Assert rst_n=0 mid-stream between clock edges -> out=0 and out_valid=0 immediately.
   - After release, in_valid=0 -> outputs stay 0.
   - Then inp=0101010 with in_valid=1 -> 00101010 one cycle later.
6. LANES=4, packed inputs {-20, +42, -64, 0} with in_valid=1 -> next cycle lanes {10010100, 00101010, 11000000, 00000000}. Then drop in_valid to 0 -> out holds and out_valid=0.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC message widths and the sign-magnitude message type used by the
// two's-complement to sign-magnitude converter.
package ldpc_pkg;

  localparam int MSG_W = 7;
  localparam int SM_W  = MSG_W + 1;

  typedef struct packed {
    logic             sign;
    logic [MSG_W-1:0] mag;
  } sm_t;

endpackage

// File: rtl/t_to_s_lane.sv
// Combinational converter for one message: W-bit two's complement in,
// (W+1)-bit {sign, magnitude} out.
module t_to_s_lane #(
  parameter int W = 7
) (
  input  logic [W-1:0] inp,
  output logic [W:0]   sm
);

  logic         sign;
  logic [W:0]   ext;
  logic [W:0]   mag;

  // Negation happens at W+1 bits so that -2^(W-1) yields magnitude 2^(W-1)
  // in the low W bits rather than wrapping back to itself.
  always_comb begin
    sign = inp[W-1];
    ext  = {inp[W-1], inp};
    mag  = sign ? (-ext) : ext;
    sm   = {sign, mag[W-1:0]};
  end

endmodule

// File: rtl/t_to_s.sv
// LANES-wide two's-complement to sign-magnitude converter with one registered
// stage; out holds its last value whenever in_valid is low.
module t_to_s
  import ldpc_pkg::*;
#(
  parameter int W     = MSG_W,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [LANES*W-1:0]     inp,
  output logic                   out_valid,
  output logic [LANES*(W+1)-1:0] out
);

  // Handshake: a beat is presented when in_valid is 1 at a rising edge and is
  // always accepted (no ready); its result appears with out_valid=1 after
  // that edge. There is no backpressure.

  logic [LANES*(W+1)-1:0] conv;
  logic [LANES*(W+1)-1:0] out_d;
  logic [LANES*(W+1)-1:0] out_q;
  logic                   out_valid_d;
  logic                   out_valid_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    t_to_s_lane #(.W(W)) u_lane (
      .inp (inp[k*W +: W]),
      .sm  (conv[k*(W+1) +: W+1])
    );
  end

  // The hold path never selects conv, so an undriven inp cannot leak out.
  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_d = conv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_t_to_s.sv
// Self-checking bench for t_to_s: a single-lane instance for the scalar tests
// and a four-lane instance for the packed-lane test.
module tb_t_to_s;
  import ldpc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  inp;
  logic        out_valid;
  logic [7:0]  out;
  logic        in_valid4;
  logic [27:0] inp4;
  logic        out_valid4;
  logic [31:0] out4;

  logic [7:0]  exp_q[$];
  logic [31:0] exp4_q[$];
  logic [7:0]  last1;
  int          checks;
  int          failures;

  t_to_s #(.W(7), .LANES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inp       (inp),
    .out_valid (out_valid),
    .out       (out)
  );

  t_to_s #(.W(7), .LANES(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .inp       (inp4),
    .out_valid (out_valid4),
    .out       (out4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_sm(input logic [6:0] v);
    int  val;
    sm_t r;
    val = int'($signed(v));
    if (val < 0) val = -val;
    r.sign = v[6];
    r.mag  = 7'(val);
    return r;
  endfunction

  task automatic test_reset_state();
    rst_n = 1'b0; in_valid = 1'b0; inp = '0; in_valid4 = 1'b0; inp4 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0 || out4 !== 32'h0 || out_valid4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out=%h v=%b out4=%h v4=%b required 0", out, out_valid, out4, out_valid4);
    end
    rst_n = 1'b1;
    last1 = 8'h00;
  endtask

  task automatic test_single();
    logic [7:0] e;
    @(negedge clk);
    in_valid = 1'b1; inp = 7'b1101100;
    exp_q.push_back(8'b10010100);
    @(negedge clk);
    in_valid = 1'b0; inp = 'x;
    e = exp_q.pop_front(); last1 = e;
    checks++;
    if (out !== e || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_m20 out=%b v=%b required %b v=1", out, out_valid, e);
    end
  endtask

  // Drives a list of inputs on consecutive edges, checking each result one edge later.
  task automatic run_burst(input string name, input logic [6:0] vals[], input logic [7:0] exps[]);
    logic [7:0] e;
    for (int i = 0; i <= vals.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front(); last1 = e;
        checks++;
        if (out !== e || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL %s[%0d] out=%b v=%b required %b v=1", name, i - 1, out, out_valid, e);
        end
      end
      if (i < vals.size()) begin
        in_valid = 1'b1; inp = vals[i];
        exp_q.push_back(exps[i]);
      end else begin
        in_valid = 1'b0; inp = 'x;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] v[] = '{7'b1111000, 7'b0101010, 7'b0010101};
    logic [7:0] e[] = '{8'b10001000, 8'b00101010, 8'b00010101};
    run_burst("back_to_back", v, e);
  endtask

  task automatic test_boundaries();
    logic [6:0] v[] = '{7'b1000000, 7'b0111111, 7'b0000000, 7'b1111111};
    logic [7:0] e[] = '{8'b11000000, 8'b00111111, 8'b00000000, 8'b10000001};
    run_burst("boundary", v, e);
  endtask

  task automatic test_sweep();
    int         i;
    logic       prev_v;
    logic [7:0] e;
    i = 0; prev_v = 1'b0;
    while (i < 128 || prev_v) begin
      @(negedge clk);
      checks++;
      if (prev_v) begin
        e = exp_q.pop_front(); last1 = e;
        if (out !== e || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL sweep_val out=%b v=%b required %b v=1", out, out_valid, e);
        end
      end else if (out !== last1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL sweep_hold out=%b v=%b required %b v=0", out, out_valid, last1);
      end
      if (i < 128 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; inp = 7'(i);
        exp_q.push_back(ref_sm(7'(i)));
        prev_v = 1'b1; i++;
      end else begin
        in_valid = 1'b0; inp = 'x;
        prev_v = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [7:0] e;
    @(negedge clk);
    in_valid = 1'b1; inp = 7'b1101100;
    exp_q.push_back(8'b10010100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete(); last1 = 8'h00;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async out=%b v=%b required 00000000 v=0", out, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0; inp = 'x;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle out=%b v=%b required 00000000 v=0", out, out_valid);
    end
    in_valid = 1'b1; inp = 7'b0101010;
    exp_q.push_back(8'b00101010);
    @(negedge clk);
    in_valid = 1'b0; inp = 'x;
    e = exp_q.pop_front(); last1 = e;
    checks++;
    if (out !== e || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first out=%b v=%b required %b v=1", out, out_valid, e);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] e;
    logic [27:0] pk;
    @(negedge clk);
    pk = {7'b1101100, 7'b0101010, 7'b1000000, 7'b0000000};
    in_valid4 = 1'b1; inp4 = pk;
    exp4_q.push_back({8'b10010100, 8'b00101010, 8'b11000000, 8'b00000000});
    @(negedge clk);
    in_valid4 = 1'b0; inp4 = 'x;
    e = exp4_q.pop_front();
    checks++;
    if (out4 !== e || out_valid4 !== 1'b1) begin
      failures++;
      $display("FAIL lanes4 out=%h v=%b required %h v=1", out4, out_valid4, e);
    end
    @(negedge clk);
    checks++;
    if (out4 !== e || out_valid4 !== 1'b0) begin
      failures++;
      $display("FAIL lanes4_hold out=%h v=%b required %h v=0", out4, out_valid4, e);
    end
    // random packed vectors, each lane checked by the reference model
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      pk = 28'($urandom);
      in_valid4 = 1'b1; inp4 = pk;
      exp4_q.push_back({ref_sm(pk[27:21]), ref_sm(pk[20:14]), ref_sm(pk[13:7]), ref_sm(pk[6:0])});
      @(negedge clk);
      in_valid4 = 1'b0; inp4 = 'x;
      e = exp4_q.pop_front();
      checks++;
      if (out4 !== e || out_valid4 !== 1'b1) begin
        failures++;
        $display("FAIL lanes4_rand[%0d] out=%h v=%b required %h v=1", n, out4, out_valid4, e);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset_state();
    test_single();
    test_back_to_back();
    test_boundaries();
    test_sweep();
    test_reset_mid_stream();
    test_lanes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
